afpm_io_sequencer: RTL
======================

Name: afpm_io_sequencer

Overview:
- Byte-serial I/O controller for the 16-bit logarithmic approximate FP multiplier core.
- Deserialises two 8-bit beats per operand (A from dedicated inputs, B from bidirectional inputs) into 16-bit operands and pulses the core start.
- Waits for core completion, with a timeout, then serialises the 16-bit result onto the 8-bit output over two beats.
- Sits between the top-level pad wrapper and the multiplier core.

Parameters:
- CORE_TIMEOUT, 15, max cycles in WAIT before abort (range 2..255).
- LSB_FIRST, 1, 1 = low byte first on input and output; 0 = high byte first.
- NAN_VALUE, 16'h7E00, result substituted on timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- data_a_in  in  8  operand A byte
- data_b_in  in  8  operand B byte
- in_valid  in  1  input beat present this cycle
- op_a  out  16  assembled operand A to core
- op_b  out  16  assembled operand B to core
- core_start  out  1  one-cycle start pulse to core
- core_result  in  16  core product
- core_done  in  1  core result valid, single-cycle pulse
- data_out  out  8  result byte
- out_valid  out  1  data_out carries a result beat
- busy  out  1  high whenever state != IDLE
- err  out  1  sticky timeout flag

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset (rst_n=0 at a clk edge): state=IDLE; op_a, op_b, result register, data_out and timer = 0; core_start, out_valid, busy, err = 0. Reset asserted mid-operation aborts immediately. No core_start or out_valid is generated afterwards for the aborted transaction.
- All outputs are registered except busy, which is decoded from state.
- States: IDLE, LOAD2, START, WAIT, OUT1, OUT2.
- IDLE:
  - If in_valid=1, capture the first beat: LSB_FIRST=1 → op_a[7:0]/op_b[7:0]; else → [15:8].
  - Clear err. Go to LOAD2.
- LOAD2:
  - If in_valid=1, capture the second beat into the other half. Go to START.
  - If in_valid=0, hold with no timeout.
- START:
  - core_start=1 for exactly this one cycle. Timer cleared to 0. Go to WAIT.
  - op_a/op_b stay stable from START until the next accepted first beat.
- WAIT:
  - Timer increments each cycle.
  - If core_done=1: latch core_result into the result register, go to OUT1.
  - Else if timer == CORE_TIMEOUT-1: load NAN_VALUE into the result register, set err=1, go to OUT1.
  - core_done in the same cycle as timeout expiry: done wins, err stays 0.
- OUT1: out_valid=1; data_out = low byte if LSB_FIRST=1, else high byte. Go to OUT2.
- OUT2: out_valid=1; data_out = the other byte. Go to IDLE.
- data_out = 8'h00 whenever out_valid=0.
- in_valid is ignored in START, WAIT, OUT1 and OUT2. Beats arriving there are dropped, not queued.
- A new first beat is accepted in IDLE only, i.e. earliest the cycle after OUT2.
- core_done is ignored outside WAIT. A done pulse arriving in START is lost; the core contract forbids it.
- Latency:
  - Second beat sampled at edge T.
  - core_start is high during cycle T..T+1.
  - With core_done sampled high at edge T+1+k (k≥1), out_valid is high for the two cycles following that edge.
  - Minimum beat-2-to-first-output distance is 3 edges.
- Throughput: one transaction per (2 + 1 + k + 2) cycles minimum.

Test Plan:
- Reset behaviour: hold rst_n=0 for 2 edges with in_valid=1 and random data → all outputs 0, busy=0, no core_start.
- Nominal transaction (LSB_FIRST=1):
  - Stimulus: beats (A,B) = (8'h00, 8'h00) then (8'h3E, 8'h42). Core model returns 16'h4480 with core_done 3 cycles after core_start.
  - Required: op_a=16'h3E00, op_b=16'h4200; single core_start pulse; out_valid 2 cycles with data_out 8'h80 then 8'h44; err=0; busy returns to 0.
- Stalled input: first beat, then in_valid=0 for 5 cycles, then second beat → remains in LOAD2 with busy=1, then completes identically to the nominal transaction.
- Timeout: core never asserts done → after CORE_TIMEOUT=15 WAIT cycles, output beats 8'h00, 8'h7E; err=1. err clears on the next accepted first beat.
- Timeout boundary: core_done asserted exactly on the cycle where timer == 14 → core_result is output, err=0.
- Ordering and ignore rules:
  - With LSB_FIRST=0, send beats 8'h3E then 8'h00 → op_a=16'h3E00, output is high byte first.
  - Toggle in_valid during WAIT/OUT1/OUT2 and pulse core_done in IDLE → no capture, no state change.

Source files
------------

// File: rtl/afpm_io_if.sv
// Byte-serial operand/result bundle between the pad wrapper, the
// multiplier core and the I/O sequencer.
interface afpm_io_if;
    logic [7:0]  data_a_in;
    logic [7:0]  data_b_in;
    logic        in_valid;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        core_start;
    logic [15:0] core_result;
    logic        core_done;
    logic [7:0]  data_out;
    logic        out_valid;
    logic        busy;
    logic        err;

    // Pad wrapper / core side: drives beats and core results.
    modport master (
        output data_a_in, data_b_in, in_valid, core_result, core_done,
        input  op_a, op_b, core_start, data_out, out_valid, busy, err
    );

    // Sequencer side.
    modport slave (
        input  data_a_in, data_b_in, in_valid, core_result, core_done,
        output op_a, op_b, core_start, data_out, out_valid, busy, err
    );
endinterface

// File: rtl/afpm_io_sequencer.sv
// Byte-serial I/O sequencer for the 16-bit logarithmic approximate FP
// multiplier: gathers two beats per operand, starts the core, waits for
// completion with a timeout, and returns the product as two output beats.
module afpm_io_sequencer #(
    parameter int unsigned CORE_TIMEOUT = 15,
    parameter bit          LSB_FIRST    = 1'b1,
    parameter logic [15:0] NAN_VALUE    = 16'h7E00
) (
    input logic     clk,
    input logic     rst_n,
    afpm_io_if.slave io
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD2 = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_OUT1  = 3'd4,
        S_OUT2  = 3'd5
    } state_t;

    // Last timer value before giving up on the core.
    localparam logic [7:0] TIMER_LAST = 8'(CORE_TIMEOUT - 1);

    state_t      state_q,      state_d;
    logic [15:0] op_a_q,       op_a_d;
    logic [15:0] op_b_q,       op_b_d;
    logic [15:0] result_q,     result_d;
    logic [7:0]  timer_q,      timer_d;
    logic        core_start_q, core_start_d;
    logic [7:0]  data_out_q,   data_out_d;
    logic        out_valid_q,  out_valid_d;
    logic        err_q,        err_d;

    // Byte of a 16-bit word that goes on the wire first.
    function automatic logic [7:0] first_byte(input logic [15:0] word);
        if (LSB_FIRST) begin
            return word[7:0];
        end else begin
            return word[15:8];
        end
    endfunction

    // Byte of a 16-bit word that goes on the wire second.
    function automatic logic [7:0] second_byte(input logic [15:0] word);
        if (LSB_FIRST) begin
            return word[15:8];
        end else begin
            return word[7:0];
        end
    endfunction

    // Next-state and next-output decode for the transaction sequence.
    always_comb begin
        state_d      = state_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        result_d     = result_q;
        timer_d      = timer_q;
        core_start_d = 1'b0;
        data_out_d   = 8'h00;
        out_valid_d  = 1'b0;
        err_d        = err_q;

        case (state_q)
            S_IDLE: begin
                if (io.in_valid) begin
                    if (LSB_FIRST) begin
                        op_a_d[7:0] = io.data_a_in;
                        op_b_d[7:0] = io.data_b_in;
                    end else begin
                        op_a_d[15:8] = io.data_a_in;
                        op_b_d[15:8] = io.data_b_in;
                    end
                    err_d   = 1'b0;
                    state_d = S_LOAD2;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD2: begin
                // No timeout here: the pad side may stall indefinitely.
                if (io.in_valid) begin
                    if (LSB_FIRST) begin
                        op_a_d[15:8] = io.data_a_in;
                        op_b_d[15:8] = io.data_b_in;
                    end else begin
                        op_a_d[7:0] = io.data_a_in;
                        op_b_d[7:0] = io.data_b_in;
                    end
                    core_start_d = 1'b1;
                    state_d      = S_START;
                end else begin
                    state_d = S_LOAD2;
                end
            end
            S_START: begin
                timer_d = 8'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 8'd1;
                // A done pulse on the expiry cycle still counts as success.
                if (io.core_done) begin
                    result_d    = io.core_result;
                    out_valid_d = 1'b1;
                    data_out_d  = first_byte(io.core_result);
                    state_d     = S_OUT1;
                end else if (timer_q == TIMER_LAST) begin
                    result_d    = NAN_VALUE;
                    err_d       = 1'b1;
                    out_valid_d = 1'b1;
                    data_out_d  = first_byte(NAN_VALUE);
                    state_d     = S_OUT1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_OUT1: begin
                out_valid_d = 1'b1;
                data_out_d  = second_byte(result_q);
                state_d     = S_OUT2;
            end
            S_OUT2: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            op_a_q       <= 16'h0000;
            op_b_q       <= 16'h0000;
            result_q     <= 16'h0000;
            timer_q      <= 8'd0;
            core_start_q <= 1'b0;
            data_out_q   <= 8'h00;
            out_valid_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            result_q     <= result_d;
            timer_q      <= timer_d;
            core_start_q <= core_start_d;
            data_out_q   <= data_out_d;
            out_valid_q  <= out_valid_d;
            err_q        <= err_d;
        end
    end

    assign io.op_a       = op_a_q;
    assign io.op_b       = op_b_q;
    assign io.core_start = core_start_q;
    assign io.data_out   = data_out_q;
    assign io.out_valid  = out_valid_q;
    assign io.err        = err_q;
    assign io.busy       = (state_q != S_IDLE);

endmodule
